period_meas: RTL and testbench
==============================

Name: period_meas

Overview:
- Downstream consumer of the frequency divider outputs (div2..div7); one instance per monitored divider output.
- Measures period and high time of a clk-synchronous square wave, in clk cycles.
- Flags a lost or stalled input and any change in the measured period.
- Used for self-check of divider ratios in simulation and as an on-chip ratio monitor.

Parameters:
n, 8, width of the period and high-time counters and outputs; maximum measurable count is 2^n-1

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous active-low reset; asserted when 0, released synchronously to clk by the source
en  input  1  measurement enable; 0 forces WAIT_RISE and clears counters
sig_in  input  1  signal under measurement (e.g. a divN output)
period  output  n  last measured period, clk cycles between consecutive rising samples
high_time  output  n  last measured high time, clk cycles sampled high within that period
meas_valid  output  1  one-cycle pulse when period/high_time update
locked  output  1  high from the first meas_valid until timeout, en=0 or reset
changed  output  1  one-cycle pulse with meas_valid when the new period differs from the previous valid period
timeout  output  1  sticky; set when the counter saturates without a rising sample; cleared by the next meas_valid, en=0 or reset

Behaviour:
- Reset (rst=0, async): state=WAIT_RISE. Counters=0, sample history=0. period=0, high_time=0; meas_valid, locked, changed and timeout=0.
- Sampling: s[k] is the sig_in value registered at posedge k. A rise occurs at k when s[k]=1 and s[k-1]=0.
- States:
  - WAIT_RISE: counters idle. On a rise: pcnt=1, hcnt=1, go to MEASURE.
  - MEASURE, no rise: pcnt+1, saturating at 2^n-1. hcnt+1 while s=1, else hold.
  - MEASURE, rise: capture period=pcnt and high_time=hcnt, then pcnt=1 and hcnt=1 and stay in MEASURE.
- Outputs update at posedge k+1, 1 cycle after the rise sample. meas_valid is high for that single cycle.
- changed: 1 with meas_valid only if locked was already 1 and the new period differs from the held period. The first measurement after lock never asserts changed.
- Timeout: pcnt reaching 2^n-1 in MEASURE sets timeout. On that same cycle, clear locked, go to WAIT_RISE, and hold period/high_time.
- A rise on the same sample where pcnt reaches 2^n-1: the rise wins. Capture the measurement, no timeout.
- en=0: WAIT_RISE, counters=0, locked=0, timeout=0, no meas_valid. period/high_time hold.
  - The sample history keeps running, so a rise already present on the first en=1 sample is detected.
- A constant-high or constant-low input never produces a rise and therefore ends in timeout.
- Reset mid-measurement aborts immediately to reset values. No partial result is emitted.
- Arithmetic: unsigned n-bit counters, no wrap; saturation is the only overflow behaviour.

Optional Feature:
SYNC_2FF_EN
- Defined: sig_in passes through a 2-flop synchronizer (reset to 0) before sampling. This allows sig_in from an unrelated clock domain. Rise-to-meas_valid latency becomes 3 cycles; measured values are unchanged for stable inputs.
- Undefined: sig_in is sampled directly; latency 1 cycle. sig_in must be synchronous to clk.

Decomposition:
- Shared package freq_pkg: state encoding (WAIT_RISE, MEASURE) and a count-max constant function for width n.
  - freq_div later reuses the package for its ratio constants.
- One sub-module edge_det: sample register, optional SYNC_2FF_EN synchronizer, rise output; async active-low reset.
- period_meas holds the FSM, counters and output registers.

Test Plan:
1. sig_in=div2 of freq_div, rst released after 2 cycles, en=1:
   - first meas_valid gives period=2, high_time=1, locked=1, changed=0;
   - every following update is identical with changed=0.
2. sig_in=div4, then switched to div6 mid-run:
   - period=4, high_time=2 while on div4;
   - first update after the switch gives period=6, high_time=3, changed=1 exactly once.
3. Directed pattern high 3 / low 5 repeated: period=8, high_time=3. meas_valid 1 cycle after each rise sample (3 with SYNC_2FF_EN).
4. n=4, sig_in held 0 after lock at period=4:
   - after 15 cycles without a rise: timeout=1, locked=0, period=4 held;
   - resume div4: next meas_valid clears timeout.
5. en deasserted mid-period with div4: no meas_valid, locked=0. Re-enable: first meas_valid is 4 cycles after the first rise, changed=0.
6. rst pulsed low asynchronously mid-measurement (between clk edges): all outputs 0 immediately. Measurement restarts cleanly after release.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared definitions for the divider family: measurement FSM encoding and
// the all-ones count limit for an n-bit counter.
package freq_pkg;

  typedef enum logic {
    WAIT_RISE = 1'b0,
    MEASURE   = 1'b1
  } meas_state_t;

  function automatic int unsigned count_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Sample register and rising-edge detect for period_meas.
// Define SYNC_2FF_EN to insert a 2-flop synchronizer ahead of the sample register.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic sampled;
  logic s_reg;
  logic s_prev_reg;

`ifdef SYNC_2FF_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= {sync_reg[0], sig_in};
  end

  assign sampled = sync_reg[1];
`else
  assign sampled = sig_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_reg      <= 1'b0;
      s_prev_reg <= 1'b0;
    end else begin
      s_reg      <= sampled;
      s_prev_reg <= s_reg;
    end
  end

  assign s    = s_reg;
  assign rise = s_reg & ~s_prev_reg;

endmodule

// File: rtl/period_meas.sv
// Period / high-time monitor for a clk-synchronous square wave (e.g. a divN output).
// Define SYNC_2FF_EN to accept an asynchronous sig_in (adds 2 cycles of latency).
module period_meas
  import freq_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sig_in,
  output logic [n-1:0] period,
  output logic [n-1:0] high_time,
  output logic         meas_valid,
  output logic         locked,
  output logic         changed,
  output logic         timeout
);

  localparam logic [n-1:0] cnt_max = n'(count_max(n));
  localparam logic [n-1:0] cnt_one = n'(1);

  meas_state_t state_reg, state_next;

  logic         s;
  logic         rise;
  logic         sat_hit;
  logic [n-1:0] pcnt_reg, pcnt_next;
  logic [n-1:0] hcnt_reg, hcnt_next;
  logic [n-1:0] period_reg, period_next;
  logic [n-1:0] high_reg, high_next;
  logic         meas_valid_reg, meas_valid_next;
  logic         locked_reg, locked_next;
  logic         changed_reg, changed_next;
  logic         timeout_reg, timeout_next;

  edge_det u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .s      (s),
    .rise   (rise)
  );

  // A rise on the saturating sample takes priority, so sat_hit excludes it.
  assign sat_hit = (state_reg == MEASURE) && !rise && (pcnt_reg == cnt_max - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= WAIT_RISE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!en) begin
      state_next = WAIT_RISE;
    end else begin
      case (state_reg)
        WAIT_RISE: if (rise) state_next = MEASURE;
        MEASURE:   if (sat_hit) state_next = WAIT_RISE;
      endcase
    end
  end

  always_comb begin
    pcnt_next       = pcnt_reg;
    hcnt_next       = hcnt_reg;
    period_next     = period_reg;
    high_next       = high_reg;
    meas_valid_next = 1'b0;
    changed_next    = 1'b0;
    locked_next     = locked_reg;
    timeout_next    = timeout_reg;
    if (!en) begin
      pcnt_next    = '0;
      hcnt_next    = '0;
      locked_next  = 1'b0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        WAIT_RISE: begin
          if (rise) begin
            pcnt_next = cnt_one;
            hcnt_next = cnt_one;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_next     = pcnt_reg;
            high_next       = hcnt_reg;
            meas_valid_next = 1'b1;
            changed_next    = locked_reg && (pcnt_reg != period_reg);
            locked_next     = 1'b1;
            timeout_next    = 1'b0;
            pcnt_next       = cnt_one;
            hcnt_next       = cnt_one;
          end else if (sat_hit) begin
            pcnt_next    = cnt_max;
            locked_next  = 1'b0;
            timeout_next = 1'b1;
          end else begin
            // hcnt never exceeds pcnt, so only pcnt needs the saturation check above
            pcnt_next = pcnt_reg + 1'b1;
            if (s) hcnt_next = hcnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_reg       <= '0;
      hcnt_reg       <= '0;
      period_reg     <= '0;
      high_reg       <= '0;
      meas_valid_reg <= 1'b0;
      locked_reg     <= 1'b0;
      changed_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      pcnt_reg       <= pcnt_next;
      hcnt_reg       <= hcnt_next;
      period_reg     <= period_next;
      high_reg       <= high_next;
      meas_valid_reg <= meas_valid_next;
      locked_reg     <= locked_next;
      changed_reg    <= changed_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign period     = period_reg;
  assign high_time  = high_reg;
  assign meas_valid = meas_valid_reg;
  assign locked     = locked_reg;
  assign changed    = changed_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_period_meas.sv
// Directed bench for period_meas (n=4); step i drives sig_in at a negedge and
// observes outputs 1 ns after the following posedge.
module tb_period_meas;

  localparam int N = 4;
`ifdef SYNC_2FF_EN
  localparam int DLY = 3;
`else
  localparam int DLY = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         sig_in = 1'b0;
  logic [N-1:0] period;
  logic [N-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         changed;
  logic         timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  period_meas #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .changed    (changed),
    .timeout    (timeout)
  );

  task automatic drive(input logic v, input logic e);
    @(negedge clk);
    sig_in = v;
    en     = e;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b0; en = 1'b1; sig_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (period !== 4'd0) begin failures++; $display("FAIL reset_period: got %0d expected 0", period); end
    checks++; if (high_time !== 4'd0) begin failures++; $display("FAIL reset_high: got %0d expected 0", high_time); end
    checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", meas_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (changed !== 1'b0) begin failures++; $display("FAIL reset_changed: got %b expected 0", changed); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    $display("reset: period=%0d high=%0d valid=%b locked=%b", period, high_time, meas_valid, locked);
  endtask

  task automatic test_div2();
    int nv = 0;
    int exp_nv = (DLY == 1) ? 9 : 8;
    restart();
    for (int i = 0; i < 20; i++) begin
      drive((i % 2) == 0, 1'b1);
      if (i == DLY + 1) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL div2_prelock: got %b expected 0", locked); end
      end
      if (meas_valid === 1'b1) begin
        nv++;
        $display("div2 step=%0d period=%0d high=%0d locked=%b changed=%b", i, period, high_time, locked, changed);
        checks++;
        if (period !== 4'd2 || high_time !== 4'd1 || locked !== 1'b1 || changed !== 1'b0) begin
          failures++;
          $display("FAIL div2_meas: got p=%0d h=%0d l=%b c=%b expected p=2 h=1 l=1 c=0", period, high_time, locked, changed);
        end
      end
    end
    checks++; if (nv != exp_nv) begin failures++; $display("FAIL div2_count: got %0d expected %0d", nv, exp_nv); end
  endtask

  task automatic test_div4_to_div6();
    int nv = 0;
    int nchg = 0;
    int r;
    logic [N-1:0] exp_p, exp_h;
    logic exp_c;
    restart();
    for (int i = 0; i < 44; i++) begin
      drive((i < 20) ? ((i % 4) < 2) : (((i - 20) % 6) < 3), 1'b1);
      if (changed === 1'b1) nchg++;
      if (meas_valid === 1'b1) begin
        nv++;
        r = i - DLY;
        exp_p = (r <= 20) ? 4'd4 : 4'd6;
        exp_h = (r <= 20) ? 4'd2 : 4'd3;
        exp_c = (r == 26);
        $display("div4_6 step=%0d period=%0d high=%0d changed=%b", i, period, high_time, changed);
        checks++;
        if (period !== exp_p || high_time !== exp_h || changed !== exp_c) begin
          failures++;
          $display("FAIL div4_6_meas: got p=%0d h=%0d c=%b expected p=%0d h=%0d c=%b", period, high_time, changed, exp_p, exp_h, exp_c);
        end
      end
    end
    checks++; if (nv != 8) begin failures++; $display("FAIL div4_6_count: got %0d expected 8", nv); end
    checks++; if (nchg != 1) begin failures++; $display("FAIL div4_6_changed_count: got %0d expected 1", nchg); end
  endtask

  task automatic test_pattern_3_5();
    logic exp_mv;
    restart();
    for (int i = 0; i < 32; i++) begin
      drive((i % 8) < 3, 1'b1);
      exp_mv = (i - DLY >= 8) && (((i - DLY) % 8) == 0);
      checks++;
      if (meas_valid !== exp_mv) begin
        failures++;
        $display("FAIL p35_valid step %0d: got %b expected %b", i, meas_valid, exp_mv);
      end
      if (exp_mv) begin
        $display("p35 step=%0d period=%0d high=%0d", i, period, high_time);
        checks++;
        if (period !== 4'd8 || high_time !== 4'd3) begin
          failures++;
          $display("FAIL p35_meas: got p=%0d h=%0d expected p=8 h=3", period, high_time);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic v;
    restart();
    for (int i = 0; i < 44; i++) begin
      v = (i < 16) ? ((i % 4) < 2) : ((i < 32) ? 1'b0 : (((i - 32) % 4) < 2));
      drive(v, 1'b1);
      if (i == 12 + DLY) begin
        checks++;
        if (meas_valid !== 1'b1 || period !== 4'd4 || locked !== 1'b1) begin
          failures++;
          $display("FAIL to_lock: got v=%b p=%0d l=%b expected v=1 p=4 l=1", meas_valid, period, locked);
        end
      end
      if (i == 25 + DLY) begin
        checks++;
        if (timeout !== 1'b0 || locked !== 1'b1) begin
          failures++;
          $display("FAIL to_early: got t=%b l=%b expected t=0 l=1", timeout, locked);
        end
      end
      if (i == 26 + DLY) begin
        $display("timeout step=%0d timeout=%b locked=%b period=%0d", i, timeout, locked, period);
        checks++;
        if (timeout !== 1'b1 || locked !== 1'b0 || period !== 4'd4 || high_time !== 4'd2) begin
          failures++;
          $display("FAIL to_set: got t=%b l=%b p=%0d h=%0d expected t=1 l=0 p=4 h=2", timeout, locked, period, high_time);
        end
      end
      if (i == 35 + DLY) begin
        checks++;
        if (timeout !== 1'b1 || meas_valid !== 1'b0) begin
          failures++;
          $display("FAIL to_sticky: got t=%b v=%b expected t=1 v=0", timeout, meas_valid);
        end
      end
      if (i == 36 + DLY) begin
        $display("resume step=%0d period=%0d timeout=%b locked=%b", i, period, timeout, locked);
        checks++;
        if (meas_valid !== 1'b1 || timeout !== 1'b0 || period !== 4'd4 || locked !== 1'b1 || changed !== 1'b0) begin
          failures++;
          $display("FAIL to_clear: got v=%b t=%b p=%0d l=%b c=%b expected v=1 t=0 p=4 l=1 c=0", meas_valid, timeout, period, locked, changed);
        end
      end
    end
  endtask

  task automatic test_enable();
    restart();
    for (int i = 0; i < 36; i++) begin
      drive((i % 4) < 2, !(i >= 10 && i < 24));
      if (i >= 10 && i <= 27 + DLY) begin
        checks++;
        if (meas_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
          failures++;
          $display("FAIL en_off step %0d: got v=%b l=%b t=%b expected 0 0 0", i, meas_valid, locked, timeout);
        end
      end
      if (i == 28 + DLY) begin
        $display("en_resume step=%0d period=%0d high=%0d changed=%b", i, period, high_time, changed);
        checks++;
        if (meas_valid !== 1'b1 || period !== 4'd4 || high_time !== 4'd2 || changed !== 1'b0 || locked !== 1'b1) begin
          failures++;
          $display("FAIL en_first: got v=%b p=%0d h=%0d c=%b l=%b expected v=1 p=4 h=2 c=0 l=1", meas_valid, period, high_time, changed, locked);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    restart();
    for (int i = 0; i < 12; i++) drive((i % 4) < 2, 1'b1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ar_prelock: got %b expected 1", locked); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    $display("async_reset: period=%0d high=%0d locked=%b", period, high_time, locked);
    checks++;
    if (period !== 4'd0 || high_time !== 4'd0 || meas_valid !== 1'b0 || locked !== 1'b0 || changed !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL ar_clear: got p=%0d h=%0d v=%b l=%b c=%b t=%b expected all 0", period, high_time, meas_valid, locked, changed, timeout);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive((i % 4) < 2, 1'b1);
      if (i < 4 + DLY) begin
        checks++;
        if (meas_valid !== 1'b0) begin failures++; $display("FAIL ar_partial step %0d: got %b expected 0", i, meas_valid); end
      end
      if (i == 4 + DLY) begin
        checks++;
        if (meas_valid !== 1'b1 || period !== 4'd4 || high_time !== 4'd2 || changed !== 1'b0 || locked !== 1'b1) begin
          failures++;
          $display("FAIL ar_restart: got v=%b p=%0d h=%0d c=%b l=%b expected v=1 p=4 h=2 c=0 l=1", meas_valid, period, high_time, changed, locked);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div4_to_div6();
    test_pattern_3_5();
    test_timeout();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
